alu_op_sequencer: RTL and testbench
===================================

# alu_op_sequencer

Multi-cycle issue controller for the shared 32-bit ALU. It accepts one operation at a time from the control unit over a valid/ready handshake and holds the operands stable on the ALU inputs. It waits a per-class latency so that long combinational paths (MUL/DIV/float) settle over several cycles. It then captures Result/ResultHi/ALUFlags and returns them to the register file as one or two write-back beats (two for SMUL/UMUL).

## Interface
Parameters:
- MUL_LAT, 2: EXEC cycles for MUL (0111), SMUL (0110), UMUL (0101); legal 1..255
- DIV_LAT, 8: EXEC cycles for DIV (0100); legal 1..255
- FP_LAT, 4: EXEC cycles for FADDS/FMULS/FADDH/FMULH (1000/1001/1110/1111); legal 1..255
- All other opcodes: 1 EXEC cycle

Ports:
- clk  in  1  system clock, rising edge
- reset_n  in  1  asynchronous, active-low reset
- req_valid  in  1  operation request
- req_ready  out  1  high only in IDLE
- req_op  in  4  ALUControl encoding
- req_a, req_b, req_imm  in  32 each  operands a, b, ExtImm
- req_rd, req_rdhi  in  4 each  destination registers (rdhi used only by SMUL/UMUL)
- req_setflags  in  1  update NZCV
- alu_ctrl  out  4  to ALU ALUControl
- alu_a, alu_b, alu_extimm  out  32 each  to ALU a, b, ExtImm; alu_a also drives ALU A
- alu_result, alu_resulthi  in  32 each  from ALU
- alu_flags  in  4  from ALU {N,Z,C,V}
- wb_valid  out  1  write-back beat valid
- wb_ready  in  1  register file accepts beat
- wb_rd  out  4  destination of current beat
- wb_data  out  32  data of current beat
- wb_last  out  1  final beat of the operation
- flags_we  out  1  one-cycle NZCV write strobe
- flags  out  4  captured {N,Z,C,V}
- dz_err  out  1  one-cycle pulse: DIV with divisor 0
- busy  out  1  state != IDLE

## Operation
- States: IDLE, EXEC, WB_LO, WB_HI.
- IDLE: req_ready=1.
  - On req_valid&req_ready, register op, a, b, imm, rd, rdhi and setflags.
  - Load the 8-bit counter with class latency-1.
  - Set is_long = (op==0101 || op==0110); set dz = (op==0100 && req_b==0).
  - Go to EXEC.
- alu_* outputs come straight from the operand registers. They change only on acceptance.
- EXEC: the counter decrements each cycle.
  - When counter==0, capture res_lo=alu_result, res_hi=alu_resulthi and flags=alu_flags, then go to WB_LO.
  - If dz is set, force res_lo=32'hFFFFFFFF, res_hi=0, flags=4'b1000, and pulse dz_err in that capture cycle. The DIV still takes the full DIV_LAT.
- WB_LO: wb_valid=1, wb_rd=rd, wb_data=res_lo, wb_last=!is_long.
  - On wb_ready: go to WB_HI if is_long, else IDLE.
  - flags_we=setflags pulses only in the first WB_LO cycle, independent of wb_ready.
- WB_HI: wb_valid=1, wb_rd=rdhi, wb_data=res_hi, wb_last=1. On wb_ready, go to IDLE.
- While wb_valid=1 and wb_ready=0, wb_rd, wb_data and wb_last stay stable.
- No new request is accepted until the state is back in IDLE: no overlap, no queue.
- Flags are taken verbatim from the ALU; the block does no flag arithmetic.

## Timing
- Acceptance edge ends cycle 0. EXEC occupies cycles 1..L (L = class latency). WB_LO is in cycle L+1.
  - With wb_ready=1: IDLE in L+2 for short ops; WB_HI in L+2 and IDLE in L+3 for long ops.
- Minimum issue interval: L+2 cycles for short ops, L+3 for long ops.
- Reset (asynchronous, any state): state=IDLE, req_ready=1, and all other outputs 0.
  - Other outputs reset to 0: wb_valid, wb_last, flags_we, dz_err, busy, flags, wb_rd, wb_data and all alu_* outputs.
  - An operation in flight is discarded: no write-back and no flags_we.
- A req_valid that is high during reset is ignored. The request is sampled from the first rising edge after reset_n deasserts.

## Test plan
- ADD 0000, a=5, b=3, rd=2, setflags=1, wb_ready=1 -> cycle 1 alu_ctrl=0000. Cycle 2: wb_valid, wb_data=8, wb_rd=2, wb_last=1, flags_we=1, flags=0000. Cycle 3: req_ready=1.
- UMUL 0101, a=0xFFFFFFFF, b=2, rd=4, rdhi=5, MUL_LAT=2 -> cycle 3: wb_data=0xFFFFFFFE, wb_rd=4, wb_last=0. Cycle 4: wb_data=0x00000001, wb_rd=5, wb_last=1.
- DIV 0100, a=10, b=0, DIV_LAT=8 -> dz_err pulse in cycle 8. Cycle 9: wb_data=0xFFFFFFFF, flags=1000. busy is high for cycles 1..9.
- SUB 0001, a=b=7, setflags=1, wb_ready held 0 for 5 cycles -> wb_data=0 and flags=0110 stay stable. flags_we is high exactly once. req_ready=0 until the beat is accepted.
- Reset pulse in cycle 4 of a DIV -> all outputs return to reset values immediately, with no wb_valid or flags_we. A following ADD 1+1 returns 2 with correct timing.
- FADDS 1000 with setflags=0, FP_LAT=4 -> wb_valid first rises in cycle 5 and flags_we never asserts.

Source files
------------

// File: rtl/alu_op_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : alu_op_sequencer
// Holds one ALU operation's operands for a per-class latency, then returns
// Result/ResultHi as one or two write-back beats.
// Revision : 1.0
// ============================================================================
module alu_op_sequencer #(
   parameter int unsigned MUL_LAT = 2,
   parameter int unsigned DIV_LAT = 8,
   parameter int unsigned FP_LAT  = 4
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic [3:0]  req_op,
   input  logic [31:0] req_a,
   input  logic [31:0] req_b,
   input  logic [31:0] req_imm,
   input  logic [3:0]  req_rd,
   input  logic [3:0]  req_rdhi,
   input  logic        req_setflags,
   output logic [3:0]  alu_ctrl,
   output logic [31:0] alu_a,
   output logic [31:0] alu_b,
   output logic [31:0] alu_extimm,
   input  logic [31:0] alu_result,
   input  logic [31:0] alu_resulthi,
   input  logic [3:0]  alu_flags,
   output logic        wb_valid,
   input  logic        wb_ready,
   output logic [3:0]  wb_rd,
   output logic [31:0] wb_data,
   output logic        wb_last,
   output logic        flags_we,
   output logic [3:0]  flags,
   output logic        dz_err,
   output logic        busy
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      EXEC  = 2'd1,
      WB_LO = 2'd2,
      WB_HI = 2'd3
   } state_t;

   localparam logic [7:0] c_mul_cnt = 8'(MUL_LAT - 1);
   localparam logic [7:0] c_div_cnt = 8'(DIV_LAT - 1);
   localparam logic [7:0] c_fp_cnt  = 8'(FP_LAT - 1);

   state_t      state_q, state_d;
   logic [3:0]  op_q, op_d;
   logic [31:0] a_q, a_d;
   logic [31:0] b_q, b_d;
   logic [31:0] imm_q, imm_d;
   logic [3:0]  rd_q, rd_d;
   logic [3:0]  rdhi_q, rdhi_d;
   logic        setflags_q, setflags_d;
   logic [7:0]  cnt_q, cnt_d;
   logic        is_long_q, is_long_d;
   logic        dz_q, dz_d;
   logic [31:0] res_lo_q, res_lo_d;
   logic [31:0] res_hi_q, res_hi_d;
   logic [3:0]  flags_q, flags_d;
   logic        first_wb_q, first_wb_d;
   logic [7:0]  lat_cnt;

   always_comb begin
      case (req_op)
         4'b0101, 4'b0110, 4'b0111:          lat_cnt = c_mul_cnt;
         4'b0100:                            lat_cnt = c_div_cnt;
         4'b1000, 4'b1001, 4'b1110, 4'b1111: lat_cnt = c_fp_cnt;
         default:                            lat_cnt = 8'd0;
      endcase
   end

   always_comb begin
      state_d    = state_q;
      op_d       = op_q;
      a_d        = a_q;
      b_d        = b_q;
      imm_d      = imm_q;
      rd_d       = rd_q;
      rdhi_d     = rdhi_q;
      setflags_d = setflags_q;
      cnt_d      = cnt_q;
      is_long_d  = is_long_q;
      dz_d       = dz_q;
      res_lo_d   = res_lo_q;
      res_hi_d   = res_hi_q;
      flags_d    = flags_q;
      first_wb_d = 1'b0;
      wb_valid   = 1'b0;
      wb_rd      = 4'd0;
      wb_data    = 32'd0;
      wb_last    = 1'b0;
      dz_err     = 1'b0;

      case (state_q)
         IDLE: begin
            if (req_valid) begin
               op_d       = req_op;
               a_d        = req_a;
               b_d        = req_b;
               imm_d      = req_imm;
               rd_d       = req_rd;
               rdhi_d     = req_rdhi;
               setflags_d = req_setflags;
               cnt_d      = lat_cnt;
               is_long_d  = (req_op == 4'b0101) || (req_op == 4'b0110);
               dz_d       = (req_op == 4'b0100) && (req_b == 32'd0);
               state_d    = EXEC;
            end
         end
         EXEC: begin
            if (cnt_q == 8'd0) begin
               // Divide-by-zero still runs the full latency, then overrides the ALU
               if (dz_q) begin
                  res_lo_d = 32'hFFFF_FFFF;
                  res_hi_d = 32'd0;
                  flags_d  = 4'b1000;
               end else begin
                  res_lo_d = alu_result;
                  res_hi_d = alu_resulthi;
                  flags_d  = alu_flags;
               end
               dz_err     = dz_q;
               first_wb_d = 1'b1;
               state_d    = WB_LO;
            end else begin
               cnt_d = cnt_q - 8'd1;
            end
         end
         WB_LO: begin
            wb_valid = 1'b1;
            wb_rd    = rd_q;
            wb_data  = res_lo_q;
            wb_last  = !is_long_q;
            if (wb_ready) begin
               state_d = is_long_q ? WB_HI : IDLE;
            end
         end
         WB_HI: begin
            wb_valid = 1'b1;
            wb_rd    = rdhi_q;
            wb_data  = res_hi_q;
            wb_last  = 1'b1;
            if (wb_ready) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   assign req_ready  = (state_q == IDLE);
   assign busy       = (state_q != IDLE);
   assign flags_we   = (state_q == WB_LO) && first_wb_q && setflags_q;
   assign flags      = flags_q;
   assign alu_ctrl   = op_q;
   assign alu_a      = a_q;
   assign alu_b      = b_q;
   assign alu_extimm = imm_q;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q    <= IDLE;
         op_q       <= 4'd0;
         a_q        <= 32'd0;
         b_q        <= 32'd0;
         imm_q      <= 32'd0;
         rd_q       <= 4'd0;
         rdhi_q     <= 4'd0;
         setflags_q <= 1'b0;
         cnt_q      <= 8'd0;
         is_long_q  <= 1'b0;
         dz_q       <= 1'b0;
         res_lo_q   <= 32'd0;
         res_hi_q   <= 32'd0;
         flags_q    <= 4'd0;
         first_wb_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         op_q       <= op_d;
         a_q        <= a_d;
         b_q        <= b_d;
         imm_q      <= imm_d;
         rd_q       <= rd_d;
         rdhi_q     <= rdhi_d;
         setflags_q <= setflags_d;
         cnt_q      <= cnt_d;
         is_long_q  <= is_long_d;
         dz_q       <= dz_d;
         res_lo_q   <= res_lo_d;
         res_hi_q   <= res_hi_d;
         flags_q    <= flags_d;
         first_wb_q <= first_wb_d;
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_alu_op_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_alu_op_sequencer
// Directed and randomized checks of alu_op_sequencer against a cycle-level
// transaction model; a behavioural ALU answers the DUT's operand outputs.
// Revision : 1.0
// ============================================================================
module tb_alu_op_sequencer;

   localparam int unsigned MUL_LAT = 2;
   localparam int unsigned DIV_LAT = 8;
   localparam int unsigned FP_LAT  = 4;

   logic        clk = 1'b0;
   logic        reset_n;
   logic        req_valid;
   logic        req_ready;
   logic [3:0]  req_op;
   logic [31:0] req_a, req_b, req_imm;
   logic [3:0]  req_rd, req_rdhi;
   logic        req_setflags;
   logic [3:0]  alu_ctrl;
   logic [31:0] alu_a, alu_b, alu_extimm;
   logic [31:0] alu_result, alu_resulthi;
   logic [3:0]  alu_flags;
   logic        wb_valid, wb_ready, wb_last;
   logic [3:0]  wb_rd;
   logic [31:0] wb_data;
   logic        flags_we;
   logic [3:0]  flags;
   logic        dz_err, busy;
   logic [144:0] all_out;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   alu_op_sequencer #(.MUL_LAT(MUL_LAT), .DIV_LAT(DIV_LAT), .FP_LAT(FP_LAT)) dut (
      .clk(clk), .reset_n(reset_n),
      .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
      .req_a(req_a), .req_b(req_b), .req_imm(req_imm),
      .req_rd(req_rd), .req_rdhi(req_rdhi), .req_setflags(req_setflags),
      .alu_ctrl(alu_ctrl), .alu_a(alu_a), .alu_b(alu_b), .alu_extimm(alu_extimm),
      .alu_result(alu_result), .alu_resulthi(alu_resulthi), .alu_flags(alu_flags),
      .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_rd(wb_rd), .wb_data(wb_data),
      .wb_last(wb_last), .flags_we(flags_we), .flags(flags), .dz_err(dz_err), .busy(busy)
   );

   assign all_out = {wb_valid, wb_last, flags_we, dz_err, busy, flags, wb_rd, alu_ctrl,
                     wb_data, alu_a, alu_b, alu_extimm};

   // Behavioural ALU: returns {N,Z,C,V, hi, lo}
   function automatic logic [67:0] alu_fn(input logic [3:0] op, input logic [31:0] a,
                                          input logic [31:0] b, input logic [31:0] imm);
      logic [32:0] s;
      logic [63:0] p;
      logic [31:0] lo, hi;
      logic        c, v;
      lo = 32'd0;
      hi = a ^ 32'h5A5A_0F0F;
      c  = a[0];
      v  = b[0];
      s  = 33'd0;
      p  = 64'd0;
      case (op)
         4'b0000: begin
            s  = {1'b0, a} + {1'b0, b};
            lo = s[31:0];
            c  = s[32];
            v  = (a[31] == b[31]) && (lo[31] != a[31]);
         end
         4'b0001: begin
            lo = a - b;
            c  = (a >= b);
            v  = (a[31] != b[31]) && (lo[31] != a[31]);
         end
         4'b0111: begin p = {32'd0, a} * {32'd0, b}; lo = p[31:0]; end
         4'b0110: begin
            p  = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
            lo = p[31:0];
            hi = p[63:32];
         end
         4'b0101: begin p = {32'd0, a} * {32'd0, b}; lo = p[31:0]; hi = p[63:32]; end
         4'b0100: lo = (b == 32'd0) ? 32'hDEAD_BEEF : a / b;
         4'b1000, 4'b1001, 4'b1110, 4'b1111: lo = a ^ {b[15:0], b[31:16]} ^ imm;
         default: lo = (a & b) ^ imm;
      endcase
      return {lo[31], (lo == 32'd0), c, v, hi, lo};
   endfunction

   assign {alu_flags, alu_resulthi, alu_result} = alu_fn(alu_ctrl, alu_a, alu_b, alu_extimm);

   // Expected captured result: divide-by-zero replaces whatever the ALU says
   function automatic logic [67:0] exp_fn(input logic [3:0] op, input logic [31:0] a,
                                          input logic [31:0] b, input logic [31:0] imm);
      if (op == 4'b0100 && b == 32'd0) return {4'b1000, 32'd0, 32'hFFFF_FFFF};
      return alu_fn(op, a, b, imm);
   endfunction

   function automatic int lat_of(input logic [3:0] op);
      case (op)
         4'b0101, 4'b0110, 4'b0111:          return int'(MUL_LAT);
         4'b0100:                            return int'(DIV_LAT);
         4'b1000, 4'b1001, 4'b1110, 4'b1111: return int'(FP_LAT);
         default:                            return 1;
      endcase
   endfunction

   task automatic drive_req(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                            input logic [31:0] imm, input logic [3:0] rd, input logic [3:0] rdhi,
                            input logic sf);
      req_valid    = 1'b1;
      req_op       = op;
      req_a        = a;
      req_b        = b;
      req_imm      = imm;
      req_rd       = rd;
      req_rdhi     = rdhi;
      req_setflags = sf;
   endtask

   task automatic test_reset();
      #2 reset_n = 1'b0;
      drive_req(4'b0000, 32'd0, 32'd0, 32'd0, 4'd1, 4'd0, 1'b0);
      @(negedge clk);
      @(negedge clk);
      checks++; if (all_out !== '0) begin errors++; $display("FAIL reset_outputs got %h exp 0", all_out); end
      checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got %b exp 1", req_ready); end
      reset_n = 1'b1;
      @(negedge clk);
      req_valid = 1'b0;
      checks++; if ({busy, req_ready} !== 2'b10) begin errors++; $display("FAIL reset_first_accept got %b exp 10", {busy, req_ready}); end
      @(negedge clk);
      checks++; if ({wb_valid, wb_data, wb_rd} !== {1'b1, 32'd0, 4'd1}) begin errors++; $display("FAIL reset_first_wb got %h exp %h", {wb_valid, wb_data, wb_rd}, {1'b1, 32'd0, 4'd1}); end
      @(negedge clk);
      checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL reset_first_done got %b exp 1", req_ready); end
   endtask

   task automatic test_add();
      wb_ready = 1'b1;
      checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL add_ready got %b exp 1", req_ready); end
      drive_req(4'b0000, 32'd5, 32'd3, 32'd0, 4'd2, 4'd0, 1'b1);
      @(negedge clk);
      req_valid = 1'b0;
      checks++; if ({alu_ctrl, alu_a, alu_b} !== {4'b0000, 32'd5, 32'd3}) begin errors++; $display("FAIL add_alu got %h exp %h", {alu_ctrl, alu_a, alu_b}, {4'b0000, 32'd5, 32'd3}); end
      checks++; if ({wb_valid, busy, req_ready} !== 3'b010) begin errors++; $display("FAIL add_exec got %b exp 010", {wb_valid, busy, req_ready}); end
      @(negedge clk);
      checks++; if ({wb_valid, wb_data, wb_rd, wb_last, flags_we, flags} !== {1'b1, 32'd8, 4'd2, 1'b1, 1'b1, 4'b0000}) begin errors++; $display("FAIL add_wb got %h exp %h", {wb_valid, wb_data, wb_rd, wb_last, flags_we, flags}, {1'b1, 32'd8, 4'd2, 1'b1, 1'b1, 4'b0000}); end
      @(negedge clk);
      checks++; if ({req_ready, wb_valid, flags_we, busy} !== 4'b1000) begin errors++; $display("FAIL add_done got %b exp 1000", {req_ready, wb_valid, flags_we, busy}); end
   endtask

   task automatic test_umul();
      drive_req(4'b0101, 32'hFFFF_FFFF, 32'd2, 32'd0, 4'd4, 4'd5, 1'b0);
      @(negedge clk);
      req_valid = 1'b0;
      @(negedge clk);
      checks++; if (wb_valid !== 1'b0) begin errors++; $display("FAIL umul_exec got %b exp 0", wb_valid); end
      @(negedge clk);
      checks++; if ({wb_valid, wb_data, wb_rd, wb_last} !== {1'b1, 32'hFFFF_FFFE, 4'd4, 1'b0}) begin errors++; $display("FAIL umul_lo got %h exp %h", {wb_valid, wb_data, wb_rd, wb_last}, {1'b1, 32'hFFFF_FFFE, 4'd4, 1'b0}); end
      @(negedge clk);
      checks++; if ({wb_valid, wb_data, wb_rd, wb_last} !== {1'b1, 32'd1, 4'd5, 1'b1}) begin errors++; $display("FAIL umul_hi got %h exp %h", {wb_valid, wb_data, wb_rd, wb_last}, {1'b1, 32'd1, 4'd5, 1'b1}); end
      @(negedge clk);
      checks++; if ({req_ready, wb_valid} !== 2'b10) begin errors++; $display("FAIL umul_done got %b exp 10", {req_ready, wb_valid}); end
   endtask

   task automatic test_div_zero();
      drive_req(4'b0100, 32'd10, 32'd0, 32'd0, 4'd3, 4'd0, 1'b1);
      for (int c = 1; c <= 10; c++) begin
         @(negedge clk);
         req_valid = 1'b0;
         checks++; if ({busy, dz_err} !== {(c <= 9), (c == 8)}) begin errors++; $display("FAIL div_busy_dz cyc=%0d got %b exp %b", c, {busy, dz_err}, {(c <= 9), (c == 8)}); end
         if (c == 9) begin
            checks++; if ({wb_valid, wb_data, flags, flags_we} !== {1'b1, 32'hFFFF_FFFF, 4'b1000, 1'b1}) begin errors++; $display("FAIL div_wb got %h exp %h", {wb_valid, wb_data, flags, flags_we}, {1'b1, 32'hFFFF_FFFF, 4'b1000, 1'b1}); end
         end
      end
   endtask

   task automatic test_backpressure();
      int fwe_count;
      fwe_count = 0;
      wb_ready  = 1'b0;
      drive_req(4'b0001, 32'd7, 32'd7, 32'd0, 4'd6, 4'd0, 1'b1);
      for (int c = 1; c <= 7; c++) begin
         @(negedge clk);
         req_valid = 1'b0;
         fwe_count += int'(flags_we);
         if (c == 1) begin
            checks++; if (req_ready !== 1'b0) begin errors++; $display("FAIL bp_exec_ready got %b exp 0", req_ready); end
         end else if (c <= 6) begin
            checks++; if ({wb_valid, wb_data, wb_rd, wb_last, flags, req_ready} !== {1'b1, 32'd0, 4'd6, 1'b1, 4'b0110, 1'b0}) begin errors++; $display("FAIL bp_hold cyc=%0d got %h exp %h", c, {wb_valid, wb_data, wb_rd, wb_last, flags, req_ready}, {1'b1, 32'd0, 4'd6, 1'b1, 4'b0110, 1'b0}); end
            if (c == 6) wb_ready = 1'b1;
         end else begin
            checks++; if ({req_ready, wb_valid} !== 2'b10) begin errors++; $display("FAIL bp_done got %b exp 10", {req_ready, wb_valid}); end
         end
      end
      checks++; if (fwe_count != 1) begin errors++; $display("FAIL bp_flags_we_count got %0d exp 1", fwe_count); end
   endtask

   task automatic test_reset_midflight();
      int bad;
      bad = 0;
      drive_req(4'b0100, 32'd100, 32'd7, 32'd0, 4'd8, 4'd0, 1'b1);
      for (int c = 1; c <= 4; c++) begin
         @(negedge clk);
         req_valid = 1'b0;
      end
      #1 reset_n = 1'b0;
      #1;
      checks++; if ({all_out, req_ready} !== {145'd0, 1'b1}) begin errors++; $display("FAIL mid_reset got %h exp %h", {all_out, req_ready}, {145'd0, 1'b1}); end
      @(negedge clk);
      reset_n = 1'b1;
      for (int c = 0; c < 12; c++) begin
         @(negedge clk);
         bad += int'(wb_valid | flags_we | busy);
      end
      checks++; if (bad != 0) begin errors++; $display("FAIL mid_discard got %0d exp 0", bad); end
      drive_req(4'b0000, 32'd1, 32'd1, 32'd0, 4'd9, 4'd0, 1'b0);
      @(negedge clk);
      req_valid = 1'b0;
      @(negedge clk);
      checks++; if ({wb_valid, wb_data, wb_rd, wb_last} !== {1'b1, 32'd2, 4'd9, 1'b1}) begin errors++; $display("FAIL mid_add got %h exp %h", {wb_valid, wb_data, wb_rd, wb_last}, {1'b1, 32'd2, 4'd9, 1'b1}); end
      @(negedge clk);
      checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL mid_add_done got %b exp 1", req_ready); end
   endtask

   task automatic test_fp_noflags();
      logic [31:0] a, b, imm;
      logic [67:0] e;
      a = $urandom; b = $urandom; imm = $urandom;
      e = exp_fn(4'b1000, a, b, imm);
      wb_ready = 1'b1;
      drive_req(4'b1000, a, b, imm, 4'd11, 4'd0, 1'b0);
      for (int c = 1; c <= 7; c++) begin
         @(negedge clk);
         req_valid = 1'b0;
         checks++; if ({wb_valid, flags_we} !== {(c == 5), 1'b0}) begin errors++; $display("FAIL fp_timing cyc=%0d got %b exp %b", c, {wb_valid, flags_we}, {(c == 5), 1'b0}); end
         if (c == 5) begin
            checks++; if (wb_data !== e[31:0]) begin errors++; $display("FAIL fp_data got %h exp %h", wb_data, e[31:0]); end
         end
      end
   endtask

   task automatic test_random(input int n_ops);
      logic [3:0]  op, rd, rdhi, e_rd;
      logic [31:0] a, b, imm, e_data;
      logic [67:0] e;
      logic        sf, dz, exp_v, e_last;
      int          lat, nb, idx, cyc, gap;
      for (int k = 0; k < n_ops; k++) begin
         gap = $urandom_range(0, 2);
         for (int g = 0; g < gap; g++) begin
            req_valid = 1'b0;
            @(negedge clk);
         end
         op   = 4'($urandom);
         a    = $urandom;
         b    = ($urandom_range(0, 3) == 0) ? 32'd0 : $urandom;
         imm  = $urandom;
         rd   = 4'($urandom);
         rdhi = 4'($urandom);
         sf   = 1'($urandom);
         checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL rnd_ready k=%0d got %b exp 1", k, req_ready); end
         drive_req(op, a, b, imm, rd, rdhi, sf);
         e   = exp_fn(op, a, b, imm);
         lat = lat_of(op);
         nb  = (op == 4'b0101 || op == 4'b0110) ? 2 : 1;
         dz  = (op == 4'b0100) && (b == 32'd0);
         idx = 0;
         cyc = 0;
         while (1) begin
            @(negedge clk);
            cyc++;
            if (cyc == 1) begin
               checks++; if ({alu_ctrl, alu_a, alu_b, alu_extimm} !== {op, a, b, imm}) begin errors++; $display("FAIL rnd_alu k=%0d got %h exp %h", k, {alu_ctrl, alu_a, alu_b, alu_extimm}, {op, a, b, imm}); end
            end
            exp_v  = (cyc > lat) && (idx < nb);
            e_rd   = (idx == 0) ? rd : rdhi;
            e_data = (idx == 0) ? e[31:0] : e[63:32];
            e_last = (idx == nb - 1);
            checks++; if ({busy, req_ready, wb_valid} !== {(idx < nb), (idx >= nb), exp_v}) begin errors++; $display("FAIL rnd_ctl k=%0d op=%h cyc=%0d got %b exp %b", k, op, cyc, {busy, req_ready, wb_valid}, {(idx < nb), (idx >= nb), exp_v}); end
            if (exp_v) begin
               checks++; if ({wb_rd, wb_data, wb_last, flags} !== {e_rd, e_data, e_last, e[67:64]}) begin errors++; $display("FAIL rnd_wb k=%0d op=%h beat=%0d got %h exp %h", k, op, idx, {wb_rd, wb_data, wb_last, flags}, {e_rd, e_data, e_last, e[67:64]}); end
            end
            checks++; if ({flags_we, dz_err} !== {(sf && cyc == lat + 1), (dz && cyc == lat)}) begin errors++; $display("FAIL rnd_pulse k=%0d op=%h cyc=%0d got %b exp %b", k, op, cyc, {flags_we, dz_err}, {(sf && cyc == lat + 1), (dz && cyc == lat)}); end
            if (idx >= nb) break;
            if (cyc > 400) begin
               errors++;
               $display("FAIL rnd_timeout k=%0d op=%h", k, op);
               break;
            end
            // DUT is busy here, so junk on the request port must be ignored
            wb_ready  = 1'($urandom);
            drive_req(4'($urandom), $urandom, $urandom, $urandom, 4'($urandom), 4'($urandom), 1'($urandom));
            req_valid = 1'($urandom);
            if (exp_v && wb_ready) idx++;
         end
      end
      req_valid = 1'b0;
      wb_ready  = 1'b1;
   endtask

   initial begin
      reset_n      = 1'b1;
      req_valid    = 1'b0;
      req_op       = 4'd0;
      req_a        = 32'd0;
      req_b        = 32'd0;
      req_imm      = 32'd0;
      req_rd       = 4'd0;
      req_rdhi     = 4'd0;
      req_setflags = 1'b0;
      wb_ready     = 1'b1;
      test_reset();
      test_add();
      test_umul();
      test_div_zero();
      test_backpressure();
      test_reset_midflight();
      test_fp_noflags();
      test_random(80);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
